// File: rtl/program_loader.sv
// Host byte-stream loader: writes an image into CPU program memory and holds the CPU in reset until complete.
// Optional checksum trailer byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADD_WIDTH  = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADD_WIDTH:0]    prog_len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  pm_wr_en,
  output logic [ADD_WIDTH-1:0]  pm_addr,
  output logic [DATA_WIDTH-1:0] pm_wr_data,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_RUN,
    S_ERR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  localparam logic [ADD_WIDTH:0] LEN_MAX = {1'b1, {ADD_WIDTH{1'b0}}};
  localparam logic [ADD_WIDTH:0] LEN_ONE = {{ADD_WIDTH{1'b0}}, 1'b1};

  state_t               state;
  logic [ADD_WIDTH:0]   len_q;
  logic [ADD_WIDTH-1:0] count;
  logic                 accept;
  logic                 len_ok;
  logic                 last_byte;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]           sum;
`endif

  assign accept    = in_valid & in_ready;
  assign len_ok    = (prog_len != '0) && (prog_len <= LEN_MAX);
  assign last_byte = ({1'b0, count} == (len_q - LEN_ONE));

  // Outputs are registered alongside the state so every flag changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      count      <= '0;
      in_ready   <= 1'b0;
      pm_wr_en   <= 1'b0;
      pm_addr    <= '0;
      pm_wr_data <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      pm_wr_en <= 1'b0;
      case (state)
        S_IDLE, S_RUN, S_ERR: begin
          if (start) begin
            cpu_rst <= 1'b1;
            done    <= 1'b0;
            if (len_ok) begin
              state    <= S_LOAD;
              len_q    <= prog_len;
              count    <= '0;
              error    <= 1'b0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              sum      <= '0;
`endif
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end

        // The address counter saturates at the final byte so pm_addr can never wrap.
        S_LOAD: begin
          if (accept) begin
            pm_wr_en   <= 1'b1;
            pm_addr    <= count;
            pm_wr_data <= in_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum        <= sum + 8'(in_data);
`endif
            if (last_byte) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state    <= S_CHK;
`else
              state    <= S_WAIT;
              in_ready <= 1'b0;
`endif
            end else begin
              count <= count + ADD_WIDTH'(1);
            end
          end
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Trailer byte is compared against the running sum and never written to memory.
        S_CHK: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (8'(in_data) == sum) begin
              state <= S_WAIT;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
`endif

        S_WAIT: begin
          state   <= S_RUN;
          busy    <= 1'b0;
          cpu_rst <= 1'b0;
          done    <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
